avalon_mem_responder: RTL
=========================

Name: avalon_mem_responder

Overview:
- Avalon-MM slave memory model. It responds to the multicycle MIPS core's memory port and is the source of the waitrequest stall that the CPU state machine holds on.
- Holds a word-addressed RAM and inserts a configurable, optionally pseudo-random, number of wait cycles before each transfer completes.
- Used in CPU testbenches as instruction/data memory, and as a stall-stress target.

Parameters:
- ADDR_W, 10, log2 of RAM depth in 32-bit words.
- BASE_ADDR, 32'hBFC0_0000, byte address mapped to word 0.
- WAIT_CYCLES, 1, fixed wait cycles per transfer; legal range 1..15.
- RANDOM_STALL, 0, when 1, adds 0..3 extra wait cycles per transfer from the LFSR.
- INIT_FILE, "", hex file loaded with $readmemh at time 0; empty string means no load.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- address  in  32  byte address from the CPU.
- read  in  1  read request.
- write  in  1  write request.
- byteenable  in  4  per-byte write enable; bit0 selects bits 7:0.
- writedata  in  32  write data.
- readdata  out  32  registered read data; valid in the cycle waitrequest is low with read high.
- waitrequest  out  1  stall signal to the CPU.

Behaviour:
- reset (posedge sample): state=IDLE, cnt=0, readdata=0, LFSR=8'hA5. RAM contents are not cleared. No write commits in the reset cycle.
- Word index = ((address - BASE_ADDR) >> 2) mod 2^ADDR_W; wraps silently. address[1:0] is ignored.
- req = read | write. waitrequest = req && (state != ACCESS), decoded combinationally from state and inputs. waitrequest = 0 when req = 0.
- N = WAIT_CYCLES + (RANDOM_STALL ? lfsr[1:0] : 0), sampled at the IDLE->busy edge and held for that transfer.
- FSM states IDLE, WAIT, ACCESS:
  - IDLE & req: N==1 -> ACCESS; else cnt <= N-1, go to WAIT. IDLE & !req: stay in IDLE.
  - WAIT & req: cnt==1 -> ACCESS; else cnt <= cnt-1.
  - WAIT & !req: this is a protocol violation -> IDLE, nothing committed.
  - ACCESS -> IDLE unconditionally. Back-to-back requests each pay the full N wait cycles.
- Timing: if req is first seen in cycle t, waitrequest is high in cycles t..t+N-1 and low in cycle t+N. The transfer completes at the edge ending cycle t+N.
- Read: on the edge entering ACCESS, readdata <= RAM[index]. Outside that edge readdata holds its last value.
- Write: on the edge leaving ACCESS (only if write is still high), each byte lane with byteenable set is written. byteenable = 0 completes the handshake but changes nothing.
- read & write both high: the write takes precedence, readdata is unchanged, and a simulation $error is issued.
- Inputs changing during WAIT: address and data are sampled when entering and leaving ACCESS; the master is required to hold them stable.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It advances every cycle that is not a reset cycle, including while idle.
- Reset mid-WAIT or mid-ACCESS: back to IDLE, no write committed, waitrequest high again next cycle if req is still asserted.

Decomposition:
- Package avalon_mem_pkg holds:
  - the state enum {IDLE, WAIT, ACCESS} as a 2-bit logic typedef;
  - the LFSR seed 8'hA5 and tap mask;
  - MAX_WAIT = 15.
- Sub-module lfsr8_stall: clk, reset, en -> 8-bit state. Keeps the random-stall generator separately testable.

Test Plan:
- WAIT_CYCLES=1. Preload RAM[0]=32'h2409_0005. Read at 0xBFC0_0000 -> waitrequest high for 1 cycle, low next cycle, readdata=32'h2409_0005 in that cycle.
- WAIT_CYCLES=3. Write 32'hDEAD_BEEF with byteenable=4'b0101 to word 4 (preloaded 0x1111_1111), then read it back. Required: waitrequest high exactly 3 cycles each time; readback = 32'h11AD_11EF.
- Write with byteenable=0 -> handshake completes after N cycles, RAM unchanged. Address BASE_ADDR + (2^ADDR_W)*4 -> aliases word 0.
- Reset asserted during the 2nd WAIT cycle of a write (WAIT_CYCLES=4) -> target word unchanged, readdata=0. With req held, the next transfer takes 4 full wait cycles.
- RANDOM_STALL=1, 200 random reads/writes against a scoreboard. Required: every stall lies in 1..WAIT_CYCLES+3, no data mismatches, and the stall sequence is identical across two runs (deterministic seed).

Source files
------------

// File: rtl/avalon_mem_pkg.sv
// rtl/avalon_mem_pkg.sv - shared types and constants for the Avalon-MM memory responder
package avalon_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } mem_state_t;

  // Stall generator seed and Fibonacci tap mask for x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Largest fixed wait count a transfer may be configured with
  localparam int unsigned MAX_WAIT = 15;

endpackage

// File: rtl/lfsr8_stall.sv
// rtl/lfsr8_stall.sv - 8-bit Fibonacci LFSR feeding the random stall extension
module lfsr8_stall
  import avalon_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] state
);

  // Shift left, feeding back the XOR of the tapped bits into bit 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LFSR_SEED;
    end else if (en) begin
      state <= {state[6:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/avalon_mem_responder.sv
// rtl/avalon_mem_responder.sv - Avalon-MM slave RAM with programmable waitrequest stalls
module avalon_mem_responder
  import avalon_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter logic [31:0] BASE_ADDR    = 32'hBFC0_0000,
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter bit          RANDOM_STALL = 1'b0,
  parameter string       INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest
);

  // Out-of-range settings are pulled back into the legal 1..MAX_WAIT window
  localparam int unsigned WAIT_N = (WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT :
                                   (WAIT_CYCLES < 1)        ? 1        : WAIT_CYCLES;

  logic [31:0]       mem [0:(1 << ADDR_W) - 1];
  mem_state_t        state;
  mem_state_t        state_next;
  logic [4:0]        cnt;
  logic [4:0]        n_xfer;
  logic [7:0]        lfsr;
  logic [31:0]       offset;
  logic [ADDR_W-1:0] index;
  logic              req;
  logic              load_read;
  logic              commit_write;
  logic              unused_bits;

  lfsr8_stall u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .state (lfsr)
  );

  // Byte address relative to the base; the upper bits wrap and the byte lane bits are ignored
  assign offset      = address - BASE_ADDR;
  assign index       = offset[ADDR_W+1:2];
  assign req         = read | write;
  assign n_xfer      = 5'(WAIT_N) + (RANDOM_STALL ? {3'b000, lfsr[1:0]} : 5'd0);
  assign unused_bits = ^{offset[31:ADDR_W+2], offset[1:0], lfsr[7:2]};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; dropping the request mid-wait abandons the transfer
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = (n_xfer == 5'd1) ? ACCESS : WAIT;
      WAIT: begin
        if (!req) begin
          state_next = IDLE;
        end else if (cnt == 5'd1) begin
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs and datapath strobes; write wins when both read and write are raised
  always_comb begin
    waitrequest  = req && (state != ACCESS);
    load_read    = (state != ACCESS) && (state_next == ACCESS) && read && !write;
    commit_write = (state == ACCESS) && write;
  end

  // Remaining wait cycles, loaded with N-1 when a transfer starts
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 5'd0;
    end else begin
      case (state)
        IDLE:    if (req) cnt <= n_xfer - 5'd1;
        WAIT:    if (req) cnt <= cnt - 5'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Read data is captured on the edge entering ACCESS and then held
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= 32'd0;
    end else if (load_read) begin
      readdata <= mem[index];
    end
  end

  // Byte-lane write on the edge leaving ACCESS; RAM contents survive reset
  always_ff @(posedge clk) begin
    if (!reset && commit_write) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) mem[index][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

  a_no_read_write: assert property (@(posedge clk) disable iff (reset) !(read && write))
    else $error("avalon_mem_responder: read and write asserted together, write takes precedence");

endmodule
